// File: rtl/clct_two_pass_sort_ctrl.sv
// Two-pass best-1-of-5 CLCT sorter: pass 1 finds clct0, pass 2 finds clct1
// with clct0's CFEB and a key-proximity busy window masked off.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   sort_start            : one-cycle strobe, candidate buses sampled with it
//   pat_in/key_in/carry_in: packed per-CFEB candidates, CFEB0 in lsbs
//   sort_busy             : sort in progress (state != IDLE)
//   start_lost            : sort_start arrived while busy and was dropped
//   clct_vld              : one-cycle pulse when clct0/clct1 outputs update
//   clct0_*/clct1_*       : best and second-best candidate, held until next sort
module clct_two_pass_sort_ctrl #(
    parameter int MXCFEB     = 5,
    parameter int MXPATB     = 6,
    parameter int MXKEYB     = 5,
    parameter int MXKEYBX    = 8,
    parameter int MXPATC     = 11,
    parameter int BUSY_WIDTH = 4,
    parameter int MIN_SORT   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sort_start,
    input  logic [MXCFEB*MXPATB-1:0] pat_in,
    input  logic [MXCFEB*MXKEYB-1:0] key_in,
    input  logic [MXCFEB*MXPATC-1:0] carry_in,
    output logic                     sort_busy,
    output logic                     start_lost,
    output logic                     clct_vld,
    output logic                     clct0_vld,
    output logic [MXPATB-1:0]        clct0_pat,
    output logic [MXKEYBX-1:0]       clct0_key,
    output logic [MXPATC-1:0]        clct0_carry,
    output logic                     clct1_vld,
    output logic [MXPATB-1:0]        clct1_pat,
    output logic [MXKEYBX-1:0]       clct1_key,
    output logic [MXPATC-1:0]        clct1_carry
);

    localparam int SKB = MXPATB - 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t state, state_nxt;

    logic [MXCFEB*MXPATB-1:0] lat_pat;
    logic [MXCFEB*MXKEYB-1:0] lat_key;
    logic [MXCFEB*MXPATC-1:0] lat_carry;

    // clct0 is kept internally after pass 1 so outputs only move at DONE
    logic                c0_vld;
    logic [MXPATB-1:0]   c0_pat;
    logic [MXKEYBX-1:0]  c0_key;
    logic [MXPATC-1:0]   c0_carry;

    logic [MXCFEB*SKB-1:0] skp;
    logic [MXCFEB-1:0]     vld;
    logic [MXCFEB-1:0]     elig2;
    logic [3:0]            p1;
    logic [3:0]            p2;

    // Returns {found, index}; strict compare keeps the lowest index on ties
    function automatic logic [3:0] pick(
        input logic [MXCFEB-1:0]     el,
        input logic [MXCFEB*SKB-1:0] keys
    );
        logic           found;
        logic [2:0]     idx;
        logic [SKB-1:0] best;
        logic [SKB-1:0] k;
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < MXCFEB; i++) begin
            k = keys[i*SKB +: SKB];
            if (el[i] && (!found || k > best)) begin
                found = 1'b1;
                idx   = 3'(i);
                best  = k;
            end
        end
        return {found, idx};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        clct_vld   = 1'b0;
        sort_busy  = (state != IDLE);
        start_lost = sort_start && (state != IDLE) && !reset;
        case (state)
            IDLE:    if (sort_start) state_nxt = PASS1;
            PASS1:   state_nxt = PASS2;
            PASS2:   state_nxt = DONE;
            DONE: begin
                clct_vld  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : sel
        logic [MXPATB-1:0]  p;
        logic [MXKEYBX-1:0] fk;
        logic [MXKEYBX:0]   a;
        logic [MXKEYBX:0]   b;
        logic [MXKEYBX:0]   d;
        skp   = '0;
        vld   = '0;
        elig2 = '0;
        for (int i = 0; i < MXCFEB; i++) begin
            p  = lat_pat[i*MXPATB +: MXPATB];
            skp[i*SKB +: SKB] = p[MXPATB-1:1];
            vld[i] = int'(p[MXPATB-1:1]) >= MIN_SORT;
            fk = {3'(i), lat_key[i*MXKEYB +: MXKEYB]};
            a  = {1'b0, fk};
            b  = {1'b0, c0_key};
            d  = (a >= b) ? a - b : b - a;
            // no wrap-around: distance is plain unsigned difference
            elig2[i] = vld[i] && c0_vld
                       && (3'(i) != c0_key[MXKEYBX-1:MXKEYB])
                       && (int'(d) > BUSY_WIDTH);
        end
        p1 = pick(vld, skp);
        p2 = pick(elig2, skp);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_pat     <= '0;
            lat_key     <= '0;
            lat_carry   <= '0;
            c0_vld      <= 1'b0;
            c0_pat      <= '0;
            c0_key      <= '0;
            c0_carry    <= '0;
            clct0_vld   <= 1'b0;
            clct0_pat   <= '0;
            clct0_key   <= '0;
            clct0_carry <= '0;
            clct1_vld   <= 1'b0;
            clct1_pat   <= '0;
            clct1_key   <= '0;
            clct1_carry <= '0;
        end else begin
            if (state == IDLE && sort_start) begin
                lat_pat   <= pat_in;
                lat_key   <= key_in;
                lat_carry <= carry_in;
            end
            if (state == PASS1) begin
                c0_vld   <= p1[3];
                c0_pat   <= p1[3] ? lat_pat[int'(p1[2:0])*MXPATB +: MXPATB] : '0;
                c0_key   <= p1[3] ? {p1[2:0], lat_key[int'(p1[2:0])*MXKEYB +: MXKEYB]} : '0;
                c0_carry <= p1[3] ? lat_carry[int'(p1[2:0])*MXPATC +: MXPATC] : '0;
            end
            if (state == PASS2) begin
                clct0_vld   <= c0_vld;
                clct0_pat   <= c0_pat;
                clct0_key   <= c0_key;
                clct0_carry <= c0_carry;
                clct1_vld   <= p2[3];
                clct1_pat   <= p2[3] ? lat_pat[int'(p2[2:0])*MXPATB +: MXPATB] : '0;
                clct1_key   <= p2[3] ? {p2[2:0], lat_key[int'(p2[2:0])*MXKEYB +: MXKEYB]} : '0;
                clct1_carry <= p2[3] ? lat_carry[int'(p2[2:0])*MXPATC +: MXPATC] : '0;
            end
        end
    end

endmodule

// File: doc/clct_two_pass_sort_ctrl.md
Name: clct_two_pass_sort_ctrl

Overview:
- Sequences best-1-of-5 pattern selection over 5 CFEB pattern-finder candidates to produce first (clct0) and second (clct1) best CLCT per sort request.
- Pass 1 picks the best candidate. Pass 2 re-runs selection with clct0's CFEB and a key-proximity busy window excluded.
- Sits between the per-CFEB pattern finders and CLCT output formatting in the TMB.

Parameters:
MXCFEB, 5, number of CFEB candidate slots (fixed 5; 3-bit CFEB index)
MXPATB, 6, pattern-ID bits; lsb = bend direction, excluded from sorting
MXKEYB, 5, half-strip key bits within one CFEB
MXKEYBX, 8, full half-strip key bits {cfeb[2:0], key[4:0]}
MXPATC, 11, comparator-code (carry) bits
BUSY_WIDTH, 4, half-strips either side of clct0 key masked for pass 2
MIN_SORT, 1, minimum sort key pat[5:1] for a candidate to count as valid

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
sort_start  in  1  one-cycle strobe; candidate buses valid this cycle
pat_in  in  MXCFEB*MXPATB  packed pattern IDs, CFEB0 in lsbs
key_in  in  MXCFEB*MXKEYB  packed per-CFEB keys
carry_in  in  MXCFEB*MXPATC  packed comparator codes
sort_busy  out  1  high while a sort is in progress
start_lost  out  1  one-cycle pulse when sort_start is dropped
clct_vld  out  1  one-cycle pulse; clct0/clct1 results updated
clct0_vld  out  1  clct0 holds a valid candidate
clct0_pat  out  MXPATB  clct0 pattern ID
clct0_key  out  MXKEYBX  clct0 full key
clct0_carry  out  MXPATC  clct0 comparator code
clct1_vld, clct1_pat, clct1_key, clct1_carry  out  same widths as clct0  second-best results

Behaviour:
- Reset: state IDLE; every output 0; input latches 0. A reset in any state aborts the sort with no clct_vld pulse.
- FSM states: IDLE, PASS1, PASS2, DONE.
  - IDLE: on sort_start, register all inputs, then go to PASS1.
  - PASS1 -> PASS2 -> DONE -> IDLE, one cycle each, unconditionally.
- Latency: sort_start at cycle N gives clct_vld at N+3.
- sort_busy = (state != IDLE).
- sort_start in any non-IDLE state: ignored, start_lost pulses that cycle, sort in progress unaffected.
- sort_start in the same cycle as reset: ignored, and start_lost does not pulse.
- Sort key = pat[MXPATB-1:1]. A candidate is valid when its sort key >= MIN_SORT.
- Selection rule, both passes: the highest sort key among eligible valid candidates wins. On ties the lowest CFEB index wins (candidate i wins only if strictly greater than every lower-index eligible candidate).
- Full key = {cfeb_index[2:0], key[4:0]}.
- PASS1: all valid candidates are eligible. Register the winner's pat, key, carry and index; clct0_vld = 1 if any candidate is valid. If none is valid, all clct0 fields are 0.
- PASS2: a candidate is eligible if valid, its CFEB differs from clct0's, and the unsigned 9-bit |fullkey - clct0_key| > BUSY_WIDTH. Register clct1 the same way as clct0.
  - If clct0_vld = 0, then clct1_vld = 0 and all clct1 fields are 0.
  - No window wrap-around: key 0 and key 159 are far apart.
- DONE: clct_vld = 1 for exactly one cycle.
- Outputs are held from the DONE cycle until the next DONE cycle or reset. Results from a sort in progress are not visible until DONE.
- The pattern lsb passes through to outputs unchanged.

Test Plan:
- Single valid candidate: CFEB2 pat=6'b101011, key=10, carry=11'h155, others pat=0 -> at N+3 clct_vld=1, clct0_vld=1, clct0_key=8'd74, clct0_pat=6'b101011, clct0_carry=11'h155, clct1_vld=0.
- Tie: CFEB1 pat=6'b100100 key=3, CFEB3 pat=6'b100101 key=20 -> clct0_key=8'd35 (CFEB1), clct1_key=8'd116, clct1_pat=6'b100101.
- Busy window:
  - Stimulus: CFEB0 pat=6'b111000 key=31; CFEB1 pat=6'b110000 key=1 (full 33, diff 2); CFEB2 pat=6'b100000 key=0 (full 64).
  - Response: clct0_key=31; clct1_key=64, clct1_pat=6'b100000.
  - Repeat with BUSY_WIDTH=1: clct1_key=33.
- Back-to-back starts: sort_start at N and N+1 -> start_lost=1 at N+1, exactly one clct_vld (at N+3), sort_busy high N+1..N+3.
- Reset mid-sort: sort_start at N, reset at N+1 -> no clct_vld, all outputs 0 at N+2. A new start at N+4 gives clct_vld at N+7.
- All pat=0 (or sort keys < MIN_SORT) -> clct_vld pulses at N+3 with clct0_vld=0, clct1_vld=0, all fields 0.
